// File: rtl/cpu_pkg.sv
// Shared definitions for the single-bus CPU control path: opcodes, sequencer states and the control word.
// Optional mul/div support is enabled by defining CONTROL_SEQUENCER_MULDIV_EN.
package cpu_pkg;

    localparam int OPW = 5;

    localparam logic [OPW-1:0] OP_ALU_FIRST = 5'b00011;
    localparam logic [OPW-1:0] OP_ALU_LAST  = 5'b01011;
    localparam logic [OPW-1:0] OP_DIV       = 5'b01111;
    localparam logic [OPW-1:0] OP_MUL       = 5'b10000;
    localparam logic [OPW-1:0] OP_JR        = 5'b10100;
    localparam logic [OPW-1:0] OP_JAL       = 5'b10101;
    localparam logic [OPW-1:0] OP_IN        = 5'b10110;
    localparam logic [OPW-1:0] OP_OUT       = 5'b10111;
    localparam logic [OPW-1:0] OP_MFHI      = 5'b11000;
    localparam logic [OPW-1:0] OP_MFLO      = 5'b11001;
    localparam logic [OPW-1:0] OP_NOP       = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT      = 5'b11011;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_e;

    typedef struct packed {
        logic           pc_out;
        logic           zhi_out;
        logic           zlo_out;
        logic           mdr_out;
        logic           hi_out;
        logic           lo_out;
        logic           inport_out;
        logic           mar_in;
        logic           z_in;
        logic           pc_in;
        logic           mdr_in;
        logic           ir_in;
        logic           y_in;
        logic           hi_in;
        logic           lo_in;
        logic           outport_in;
        logic           gra;
        logic           grb;
        logic           grc;
        logic           r_in;
        logic           r_out;
        logic           inc_pc;
        logic           mem_read;
        logic           mem_enable;
        logic [OPW-1:0] alu_op;
        logic           running;
        logic           halted;
    } ctrl_word_t;

    function automatic logic is_alu(input logic [OPW-1:0] op);
        return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
    endfunction

    function automatic logic is_muldiv(input logic [OPW-1:0] op);
`ifdef CONTROL_SEQUENCER_MULDIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == OP_MUL) && 1'b0;
`endif
    endfunction

    // Opcodes that have an execute sequence starting at T3 (nop never reaches T3).
    function automatic logic op_supported(input logic [OPW-1:0] op);
        return is_alu(op) || is_muldiv(op) ||
               (op == OP_IN)   || (op == OP_OUT)  || (op == OP_MFHI) ||
               (op == OP_MFLO) || (op == OP_JR)   || (op == OP_JAL)  ||
               (op == OP_HALT);
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational map from (sequencer state, IR opcode) to the datapath control word.
// mul/div execute steps decode only when CONTROL_SEQUENCER_MULDIV_EN is defined.
module control_decoder
    import cpu_pkg::*;
(
    input  state_e               state,
    input  logic [OPW-1:0]       ir_opcode,
    output ctrl_word_t           cw
);

    // Strobe decode per step; anything not set here stays 0.
    always_comb begin
        cw = '0;
        case (state)
            ST_T0: begin
                cw.running = 1'b1;
                cw.pc_out  = 1'b1;
                cw.inc_pc  = 1'b1;
                cw.mar_in  = 1'b1;
                cw.z_in    = 1'b1;
            end
            ST_T1: begin
                cw.running    = 1'b1;
                cw.zlo_out    = 1'b1;
                cw.pc_in      = 1'b1;
                cw.mdr_in     = 1'b1;
                cw.mem_read   = 1'b1;
                cw.mem_enable = 1'b1;
            end
            ST_T2: begin
                cw.running = 1'b1;
                cw.mdr_out = 1'b1;
                cw.ir_in   = 1'b1;
            end
            ST_T3: begin
                cw.running = 1'b1;
                case (ir_opcode)
                    OP_IN:   begin cw.gra = 1'b1; cw.r_in  = 1'b1; cw.inport_out = 1'b1; end
                    OP_OUT:  begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.outport_in = 1'b1; end
                    OP_MFHI: begin cw.gra = 1'b1; cw.r_in  = 1'b1; cw.hi_out     = 1'b1; end
                    OP_MFLO: begin cw.gra = 1'b1; cw.r_in  = 1'b1; cw.lo_out     = 1'b1; end
                    OP_JR:   begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.pc_in      = 1'b1; end
                    // Link register R15 is selected through the IR Rb field.
                    OP_JAL:  begin cw.grb = 1'b1; cw.r_in  = 1'b1; cw.pc_out     = 1'b1; end
                    default: begin
                        if (is_alu(ir_opcode)) begin
                            cw.grb   = 1'b1;
                            cw.r_out = 1'b1;
                            cw.y_in  = 1'b1;
                        end else if (is_muldiv(ir_opcode)) begin
                            cw.gra   = 1'b1;
                            cw.r_out = 1'b1;
                            cw.y_in  = 1'b1;
                        end else begin
                            cw.running = 1'b1;
                        end
                    end
                endcase
            end
            ST_T4: begin
                cw.running = 1'b1;
                if (ir_opcode == OP_JAL) begin
                    cw.gra   = 1'b1;
                    cw.r_out = 1'b1;
                    cw.pc_in = 1'b1;
                end else if (is_alu(ir_opcode)) begin
                    cw.grc    = 1'b1;
                    cw.r_out  = 1'b1;
                    cw.z_in   = 1'b1;
                    cw.alu_op = ir_opcode;
                end else if (is_muldiv(ir_opcode)) begin
                    cw.grb    = 1'b1;
                    cw.r_out  = 1'b1;
                    cw.z_in   = 1'b1;
                    cw.alu_op = ir_opcode;
                end else begin
                    cw.running = 1'b1;
                end
            end
            ST_T5: begin
                cw.running = 1'b1;
                if (is_alu(ir_opcode)) begin
                    cw.zlo_out = 1'b1;
                    cw.gra     = 1'b1;
                    cw.r_in    = 1'b1;
                end else if (is_muldiv(ir_opcode)) begin
                    cw.zlo_out = 1'b1;
                    cw.lo_in   = 1'b1;
                end else begin
                    cw.running = 1'b1;
                end
            end
            ST_T6: begin
                cw.running = 1'b1;
                if (is_muldiv(ir_opcode)) begin
                    cw.zhi_out = 1'b1;
                    cw.hi_in   = 1'b1;
                end else begin
                    cw.running = 1'b1;
                end
            end
            ST_HALT: cw.halted = 1'b1;
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the single-bus CPU: state register, next-state logic, sticky Illegal flag.
// Define CONTROL_SEQUENCER_MULDIV_EN to add the seven-cycle mul/div sequence.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic           Clock,
    input  logic           clear,
    input  logic           Run,
    input  logic           Stop,
    input  logic [OPW-1:0] IR_opcode,
    output logic           PCout,
    output logic           Zhi_out,
    output logic           Zlo_out,
    output logic           MDRout,
    output logic           HIout,
    output logic           LOout,
    output logic           Inport_out,
    output logic           MARin,
    output logic           Zin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           HIin,
    output logic           LOin,
    output logic           outport_in,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           IncPC,
    output logic           Mem_Read,
    output logic           Mem_enable512x32,
    output logic [OPW-1:0] opcode,
    output logic           Running,
    output logic           Halted,
    output logic           Illegal
);

    state_e     state_r;
    state_e     state_next_s;
    state_e     eoi_next_s;
    logic       eoi_s;
    logic       illegal_r;
    ctrl_word_t cw_s;

    assign eoi_next_s = Stop ? ST_IDLE : ST_T0;

    // End-of-instruction detection: the step where the opcode's sequence finishes.
    always_comb begin
        eoi_s = 1'b0;
        case (state_r)
            ST_T2:   eoi_s = (IR_opcode == OP_NOP);
            ST_T3:   eoi_s = !((IR_opcode == OP_JAL) || (IR_opcode == OP_HALT) ||
                               is_alu(IR_opcode) || is_muldiv(IR_opcode));
            ST_T4:   eoi_s = (IR_opcode == OP_JAL);
            ST_T5:   eoi_s = is_alu(IR_opcode);
            ST_T6:   eoi_s = 1'b1;
            default: eoi_s = 1'b0;
        endcase
    end

    // Next-state selection; Stop only matters at EOI.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: state_next_s = Run ? ST_T0 : ST_IDLE;
            ST_T0:   state_next_s = ST_T1;
            ST_T1:   state_next_s = ST_T2;
            ST_T2:   state_next_s = eoi_s ? eoi_next_s : ST_T3;
            ST_T3: begin
                if (IR_opcode == OP_HALT) begin
                    state_next_s = ST_HALT;
                end else if (eoi_s) begin
                    state_next_s = eoi_next_s;
                end else begin
                    state_next_s = ST_T4;
                end
            end
            ST_T4:   state_next_s = eoi_s ? eoi_next_s : ST_T5;
            ST_T5:   state_next_s = eoi_s ? eoi_next_s : ST_T6;
            ST_T6:   state_next_s = eoi_next_s;
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register; clear aborts any instruction in flight.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sticky flag for an unsupported opcode seen at T3.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            illegal_r <= 1'b0;
        end else if ((state_r == ST_T3) && !op_supported(IR_opcode)) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    control_decoder u_decoder (
        .state     (state_r),
        .ir_opcode (IR_opcode),
        .cw        (cw_s)
    );

    assign PCout            = cw_s.pc_out;
    assign Zhi_out          = cw_s.zhi_out;
    assign Zlo_out          = cw_s.zlo_out;
    assign MDRout           = cw_s.mdr_out;
    assign HIout            = cw_s.hi_out;
    assign LOout            = cw_s.lo_out;
    assign Inport_out       = cw_s.inport_out;
    assign MARin            = cw_s.mar_in;
    assign Zin              = cw_s.z_in;
    assign PCin             = cw_s.pc_in;
    assign MDRin            = cw_s.mdr_in;
    assign IRin             = cw_s.ir_in;
    assign Yin              = cw_s.y_in;
    assign HIin             = cw_s.hi_in;
    assign LOin             = cw_s.lo_in;
    assign outport_in       = cw_s.outport_in;
    assign Gra              = cw_s.gra;
    assign Grb              = cw_s.grb;
    assign Grc              = cw_s.grc;
    assign Rin              = cw_s.r_in;
    assign Rout             = cw_s.r_out;
    assign IncPC            = cw_s.inc_pc;
    assign Mem_Read         = cw_s.mem_read;
    assign Mem_enable512x32 = cw_s.mem_enable;
    assign opcode           = cw_s.alu_op;
    assign Running          = cw_s.running;
    assign Halted           = cw_s.halted;
    assign Illegal          = illegal_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instructions followed by random ones,
// each compared cycle by cycle against per-instruction strobe lists built from the opcode class.
module tb_control_sequencer;

    logic       Clock = 1'b0;
    logic       clear, Run, Stop;
    logic [4:0] IR_opcode;
    logic       PCout, Zhi_out, Zlo_out, MDRout, HIout, LOout, Inport_out;
    logic       MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, outport_in;
    logic       Gra, Grb, Grc, Rin, Rout, IncPC, Mem_Read, Mem_enable512x32;
    logic [4:0] opcode;
    logic       Running, Halted, Illegal;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .Run(Run), .Stop(Stop), .IR_opcode(IR_opcode),
        .PCout(PCout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Inport_out(Inport_out), .MARin(MARin),
        .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .outport_in(outport_in), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .IncPC(IncPC), .Mem_Read(Mem_Read),
        .Mem_enable512x32(Mem_enable512x32), .opcode(opcode), .Running(Running),
        .Halted(Halted), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    localparam logic [31:0] M_PCOUT  = 32'h0000_0001;
    localparam logic [31:0] M_ZHI    = 32'h0000_0002;
    localparam logic [31:0] M_ZLO    = 32'h0000_0004;
    localparam logic [31:0] M_MDROUT = 32'h0000_0008;
    localparam logic [31:0] M_HIOUT  = 32'h0000_0010;
    localparam logic [31:0] M_LOOUT  = 32'h0000_0020;
    localparam logic [31:0] M_INP    = 32'h0000_0040;
    localparam logic [31:0] M_MARIN  = 32'h0000_0080;
    localparam logic [31:0] M_ZIN    = 32'h0000_0100;
    localparam logic [31:0] M_PCIN   = 32'h0000_0200;
    localparam logic [31:0] M_MDRIN  = 32'h0000_0400;
    localparam logic [31:0] M_IRIN   = 32'h0000_0800;
    localparam logic [31:0] M_YIN    = 32'h0000_1000;
    localparam logic [31:0] M_HIIN   = 32'h0000_2000;
    localparam logic [31:0] M_LOIN   = 32'h0000_4000;
    localparam logic [31:0] M_OUTP   = 32'h0000_8000;
    localparam logic [31:0] M_GRA    = 32'h0001_0000;
    localparam logic [31:0] M_GRB    = 32'h0002_0000;
    localparam logic [31:0] M_GRC    = 32'h0004_0000;
    localparam logic [31:0] M_RIN    = 32'h0008_0000;
    localparam logic [31:0] M_ROUT   = 32'h0010_0000;
    localparam logic [31:0] M_INCPC  = 32'h0020_0000;
    localparam logic [31:0] M_MRD    = 32'h0040_0000;
    localparam logic [31:0] M_MEN    = 32'h0080_0000;
    localparam logic [31:0] M_RUN    = 32'h0100_0000;
    localparam logic [31:0] M_HALT   = 32'h0200_0000;
    localparam logic [31:0] M_ILL    = 32'h0400_0000;

    logic [31:0] obs;
    assign obs = {opcode, Illegal, Halted, Running, Mem_enable512x32, Mem_Read, IncPC,
                  Rout, Rin, Grc, Grb, Gra, outport_in, LOin, HIin, Yin, IRin, MDRin,
                  PCin, Zin, MARin, Inport_out, LOout, HIout, MDRout, Zlo_out, Zhi_out, PCout};

    int          vectors = 0;
    int          miscompares = 0;
    logic        ill_exp = 1'b0;
    logic        in_idle = 1'b1;
    logic [31:0] exp_q[$];

    function automatic logic m_alu(input logic [4:0] op);
        return (op >= 5'd3) && (op <= 5'd11);
    endfunction

    function automatic logic m_muldiv(input logic [4:0] op);
`ifdef CONTROL_SEQUENCER_MULDIV_EN
        return (op == 5'd16) || (op == 5'd15);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_illegal(input logic [4:0] op);
        return !(m_alu(op) || m_muldiv(op) || ((op >= 5'd20) && (op <= 5'd27)));
    endfunction

    // Builds the whole expected strobe sequence of one instruction, T0 through its last step.
    task automatic plan(input logic [4:0] op);
        logic [31:0] opf;
        opf = {op, 27'd0};
        exp_q.delete();
        exp_q.push_back(M_RUN | M_PCOUT | M_INCPC | M_MARIN | M_ZIN);
        exp_q.push_back(M_RUN | M_ZLO | M_PCIN | M_MDRIN | M_MRD | M_MEN);
        exp_q.push_back(M_RUN | M_MDROUT | M_IRIN);
        case (op)
            5'd22: exp_q.push_back(M_RUN | M_GRA | M_RIN | M_INP);
            5'd23: exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_OUTP);
            5'd24: exp_q.push_back(M_RUN | M_GRA | M_RIN | M_HIOUT);
            5'd25: exp_q.push_back(M_RUN | M_GRA | M_RIN | M_LOOUT);
            5'd20: exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_PCIN);
            5'd21: begin
                exp_q.push_back(M_RUN | M_GRB | M_RIN | M_PCOUT);
                exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_PCIN);
            end
            5'd26: exp_q.push_back(32'd0);
            5'd27: exp_q.push_back(M_RUN);
            default: begin
                if (m_alu(op)) begin
                    exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
                    exp_q.push_back(M_RUN | M_GRC | M_ROUT | M_ZIN | opf);
                    exp_q.push_back(M_RUN | M_ZLO | M_GRA | M_RIN);
                end else if (m_muldiv(op)) begin
                    exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_YIN);
                    exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_ZIN | opf);
                    exp_q.push_back(M_RUN | M_ZLO | M_LOIN);
                    exp_q.push_back(M_RUN | M_ZHI | M_HIIN);
                end else begin
                    exp_q.push_back(M_RUN);
                end
            end
        endcase
        if (op == 5'd26) void'(exp_q.pop_back());
    endtask

    task automatic check(input string tag, input logic [31:0] expv);
        logic [31:0] e;
        e = expv | (ill_exp ? M_ILL : 32'd0);
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic cycle_check(input string tag, input logic [31:0] expv);
        @(negedge Clock);
        check(tag, expv);
        @(posedge Clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b0;
        ill_exp = 1'b0;
        #1;
        check("clear_async", 32'd0);
        Run = 1'b1;
        @(negedge Clock);
        check("clear_hold", 32'd0);
        @(posedge Clock);
        #1;
        clear = 1'b1;
        Run = 1'b0;
        in_idle = 1'b1;
        cycle_check("post_clear_idle", 32'd0);
    endtask

    // One instruction from IDLE or from the T0 following a previous EOI; abort_at >= 0 pulls clear at that step.
    task automatic run_instr(input string tag, input logic [4:0] op, input logic stop_eoi, input int abort_at);
        int n;
        if (in_idle) begin
            if ($urandom_range(0, 1) == 1) begin
                Run = 1'b0; Stop = 1'($urandom); IR_opcode = 5'($urandom);
                cycle_check("idle_hold", 32'd0);
            end
            Run = 1'b1; Stop = 1'($urandom); IR_opcode = 5'($urandom);
            cycle_check("idle_run", 32'd0);
        end
        plan(op);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            Run = 1'($urandom);
            IR_opcode = (i < 2) ? 5'($urandom) : op;
            Stop = (i == n - 1) ? stop_eoi : 1'($urandom);
            cycle_check($sformatf("%s_op%0d_step%0d", tag, op, i), exp_q[i]);
            if (i == abort_at) begin
                do_clear();
                return;
            end
            if ((i == 3) && m_illegal(op)) ill_exp = 1'b1;
        end
        if (op == 5'd27) begin
            for (int k = 0; k < 4; k++) begin
                Run = 1'b1; Stop = 1'($urandom);
                cycle_check("halted", M_HALT);
            end
            do_clear();
        end else begin
            in_idle = stop_eoi;
        end
    endtask

    initial begin
        clear = 1'b0; Run = 1'b0; Stop = 1'b0; IR_opcode = 5'd0;
        repeat (2) @(posedge Clock);
        #1;
        @(negedge Clock);
        check("in_reset", 32'd0);
        @(posedge Clock);
        #1;
        clear = 1'b1;
        cycle_check("reset_idle0", 32'd0);
        cycle_check("reset_idle1", 32'd0);

        run_instr("in",   5'd22, 1'b0, -1);
        run_instr("jal",  5'd21, 1'b0, -1);
        run_instr("add",  5'd3,  1'b1, -1);
        run_instr("ill",  5'd31, 1'b0, -1);
        run_instr("mul",  5'd16, 1'b0, -1);
        run_instr("div",  5'd15, 1'b0, -1);
        run_instr("nop",  5'd26, 1'b0, -1);
        run_instr("nop",  5'd26, 1'b1, -1);
        run_instr("out",  5'd23, 1'b0, -1);
        run_instr("mfhi", 5'd24, 1'b0, -1);
        run_instr("mflo", 5'd25, 1'b0, -1);
        run_instr("jr",   5'd20, 1'b1, -1);
        run_instr("abrt", 5'd11, 1'b0, 4);
        run_instr("halt", 5'd27, 1'b0, -1);

        for (int r = 0; r < 60; r++) begin
            logic [4:0] op;
            int         ab;
            op = 5'($urandom);
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_instr("rnd", op, 1'($urandom), ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
